crtc_timing: RTL and testbench

Video timing generator downstream of the CRTC register file. Consumes the programmed 6545-style register values (R0–R9, R12–R13) and produces the raster timing: HSync, VSync, display enable, 14-bit character memory address (MA) and 5-bit scan-line row address (RA). The character/glyph fetch logic uses MA/RA, and the video output stage uses the sync and enable signals. It replaces the fixed-rate hvSync divider with register-programmable timing.

---
 rtl/crtc_pkg.sv | 35 +++
 rtl/crtc_if.sv | 34 +++
 rtl/crtc_sync_pulse.sv | 39 +++
 rtl/crtc_timing.sv | 144 ++++++++++++++
 tb/tb_crtc_timing.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/crtc_pkg.sv
// Shared constants and types for the CRTC raster timing generator.
package crtc_pkg;

    localparam int unsigned R0  = 0;
    localparam int unsigned R1  = 1;
    localparam int unsigned R2  = 2;
    localparam int unsigned R3  = 3;
    localparam int unsigned R4  = 4;
    localparam int unsigned R5  = 5;
    localparam int unsigned R6  = 6;
    localparam int unsigned R7  = 7;
    localparam int unsigned R8  = 8;
    localparam int unsigned R9  = 9;
    localparam int unsigned R10 = 10;
    localparam int unsigned R11 = 11;
    localparam int unsigned R12 = 12;
    localparam int unsigned R13 = 13;
    localparam int unsigned R14 = 14;
    localparam int unsigned R15 = 15;
    localparam int unsigned R16 = 16;
    localparam int unsigned R17 = 17;

    localparam int unsigned MA_W  = 14;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned ROW_W = 7;
    localparam int unsigned HC_W  = 8;

    localparam int unsigned SYNC_W_ZERO = 16;

    typedef enum logic {
        V_ROWS,
        V_ADJ
    } v_state_t;

endpackage

// File: rtl/crtc_if.sv
// Register values into, and raster timing out of, the CRTC timing generator.
interface crtc_if;

    logic [7:0]                  r0_h_total;
    logic [7:0]                  r1_h_disp;
    logic [7:0]                  r2_h_sync_pos;
    logic [7:0]                  r3_sync_width;
    logic [crtc_pkg::ROW_W-1:0]  r4_v_total;
    logic [crtc_pkg::RA_W-1:0]   r5_v_adjust;
    logic [crtc_pkg::ROW_W-1:0]  r6_v_disp;
    logic [crtc_pkg::ROW_W-1:0]  r7_v_sync_pos;
    logic [crtc_pkg::RA_W-1:0]   r9_max_scan;
    logic [crtc_pkg::MA_W-1:0]   start_addr;

    logic                        h_sync;
    logic                        v_sync;
    logic                        de;
    logic [crtc_pkg::MA_W-1:0]   ma;
    logic [crtc_pkg::RA_W-1:0]   ra;
    logic                        frame_start;

    modport master (
        output r0_h_total, r1_h_disp, r2_h_sync_pos, r3_sync_width, r4_v_total,
               r5_v_adjust, r6_v_disp, r7_v_sync_pos, r9_max_scan, start_addr,
        input  h_sync, v_sync, de, ma, ra, frame_start
    );

    modport slave (
        input  r0_h_total, r1_h_disp, r2_h_sync_pos, r3_sync_width, r4_v_total,
               r5_v_adjust, r6_v_disp, r7_v_sync_pos, r9_max_scan, start_addr,
        output h_sync, v_sync, de, ma, ra, frame_start
    );

endinterface

// File: rtl/crtc_sync_pulse.sv
// Retriggerable sync pulse of 1..16 steps; a width field of 0 means 16.
module crtc_sync_pulse
    import crtc_pkg::*;
(
    input  logic       clk,
    input  logic       res_b,
    input  logic       step,
    input  logic       trig,
    input  logic [3:0] width,
    output logic       pulse
);

    logic [4:0] width_full;
    logic [4:0] remain_q;
    logic       pulse_q;

    assign width_full = (width == 4'd0) ? 5'(SYNC_W_ZERO) : {1'b0, width};

    // remain_q counts the active steps still owed after the current one.
    always_ff @(posedge clk) begin
        if (!res_b) begin
            remain_q <= '0;
            pulse_q  <= 1'b0;
        end else if (step) begin
            if (trig) begin
                remain_q <= width_full - 5'd1;
                pulse_q  <= 1'b1;
            end else if (remain_q != 5'd0) begin
                remain_q <= remain_q - 5'd1;
                pulse_q  <= 1'b1;
            end else begin
                pulse_q  <= 1'b0;
            end
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/crtc_timing.sv
// Register-programmable raster timing: character/scan-line/row counters, MA, sync and DE.
module crtc_timing
    import crtc_pkg::*;
(
    input  logic   clk16,
    input  logic   res_b,
    input  logic   cclk_en,
    crtc_if.slave  bus
);

    logic [HC_W-1:0]  hc_q, hc_d;
    logic [RA_W-1:0]  ra_q, ra_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [RA_W-1:0]  adj_q, adj_d;
    logic [MA_W-1:0]  ma_q, ma_d;
    logic [MA_W-1:0]  row_start_q, row_start_d;
    logic [MA_W-1:0]  rs_next;
    v_state_t         state_q, state_d;
    logic             de_q, de_d;
    logic             fs_q;
    logic             eol;
    logic             new_frame;
    logic             h_trig;
    logic             v_trig;
    logic             h_sync;
    logic             v_sync;

    always_comb begin
        hc_d        = hc_q + 8'd1;
        ra_d        = ra_q;
        row_d       = row_q;
        adj_d       = adj_q;
        state_d     = state_q;
        ma_d        = ma_q + 14'd1;
        row_start_d = row_start_q;
        rs_next     = row_start_q;
        new_frame   = 1'b0;
        eol         = (hc_q == bus.r0_h_total);

        if (eol) begin
            hc_d = '0;
            // Row base advances only after the last scan line of a row.
            if (ra_q == bus.r9_max_scan) begin
                rs_next = row_start_q + MA_W'(bus.r1_h_disp);
            end
            row_start_d = rs_next;
            ma_d        = rs_next;

            case (state_q)
                V_ROWS: begin
                    if (ra_q < bus.r9_max_scan) begin
                        ra_d = ra_q + 5'd1;
                    end else begin
                        ra_d = '0;
                        if (row_q == bus.r4_v_total) begin
                            if (bus.r5_v_adjust != 5'd0) begin
                                state_d = V_ADJ;
                                adj_d   = '0;
                            end else begin
                                new_frame = 1'b1;
                            end
                        end else begin
                            row_d = row_q + 7'd1;
                        end
                    end
                end
                V_ADJ: begin
                    if (({1'b0, adj_q} + 6'd1) >= {1'b0, bus.r5_v_adjust}) begin
                        new_frame = 1'b1;
                    end else begin
                        adj_d = adj_q + 5'd1;
                    end
                end
                default: ;
            endcase

            if (new_frame) begin
                row_d       = '0;
                ra_d        = '0;
                adj_d       = '0;
                state_d     = V_ROWS;
                ma_d        = bus.start_addr;
                row_start_d = bus.start_addr;
            end
        end

        // Outputs decode the post-step counters so they line up with the new hc.
        de_d   = (hc_d < bus.r1_h_disp) && (row_d < bus.r6_v_disp) && (state_d == V_ROWS);
        h_trig = (hc_d == bus.r2_h_sync_pos);
        v_trig = (state_d == V_ROWS) && (row_d == bus.r7_v_sync_pos) && (ra_d == '0);
    end

    always_ff @(posedge clk16) begin
        if (!res_b) begin
            hc_q        <= '0;
            ra_q        <= '0;
            row_q       <= '0;
            adj_q       <= '0;
            state_q     <= V_ROWS;
            ma_q        <= '0;
            row_start_q <= '0;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            fs_q <= cclk_en && new_frame;
            if (cclk_en) begin
                hc_q        <= hc_d;
                ra_q        <= ra_d;
                row_q       <= row_d;
                adj_q       <= adj_d;
                state_q     <= state_d;
                ma_q        <= ma_d;
                row_start_q <= row_start_d;
                de_q        <= de_d;
            end
        end
    end

    crtc_sync_pulse u_h_sync (
        .clk   (clk16),
        .res_b (res_b),
        .step  (cclk_en),
        .trig  (h_trig),
        .width (bus.r3_sync_width[3:0]),
        .pulse (h_sync)
    );

    crtc_sync_pulse u_v_sync (
        .clk   (clk16),
        .res_b (res_b),
        .step  (cclk_en && eol),
        .trig  (v_trig),
        .width (bus.r3_sync_width[7:4]),
        .pulse (v_sync)
    );

    assign bus.h_sync      = h_sync;
    assign bus.v_sync      = v_sync;
    assign bus.de          = de_q;
    assign bus.ma          = ma_q;
    assign bus.ra          = ra_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_crtc_timing.sv
// Randomised bench for crtc_timing against a frame-arithmetic reference model.
module tb_crtc_timing;
    import crtc_pkg::*;

    logic clk16   = 1'b0;
    logic res_b   = 1'b0;
    logic cclk_en = 1'b0;

    logic [7:0]       r0, r1, r2, r3;
    logic [ROW_W-1:0] r4, r6, r7;
    logic [RA_W-1:0]  r5, r9;
    logic [MA_W-1:0]  sa;

    crtc_if bus ();

    assign bus.r0_h_total    = r0;
    assign bus.r1_h_disp     = r1;
    assign bus.r2_h_sync_pos = r2;
    assign bus.r3_sync_width = r3;
    assign bus.r4_v_total    = r4;
    assign bus.r5_v_adjust   = r5;
    assign bus.r6_v_disp     = r6;
    assign bus.r7_v_sync_pos = r7;
    assign bus.r9_max_scan   = r9;
    assign bus.start_addr    = sa;

    crtc_timing dut (
        .clk16   (clk16),
        .res_b   (res_b),
        .cclk_en (cclk_en),
        .bus     (bus.slave)
    );

    always #5 clk16 = ~clk16;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned t_char  = 0;  // character times since reset
    int          cyc     = 0;
    int          last_fs = -1;
    logic        fs_exp  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t_char=%0d)", tag, obs, exp, t_char);
        end
    endtask

    function automatic int unsigned frame_chars();
        return (int'(r0) + 1) * ((int'(r4) + 1) * (int'(r9) + 1) + int'(r5));
    endfunction

    // Returns {h_sync, v_sync, de, ma, ra} for the raster position t characters after reset.
    function automatic logic [21:0] model(input int unsigned t);
        int unsigned hcn   = int'(r0) + 1;
        int unsigned sl    = int'(r9) + 1;
        int unsigned rowl  = (int'(r4) + 1) * sl;
        int unsigned fl    = rowl + int'(r5);
        int unsigned wh    = (r3[3:0] == 4'd0) ? 16 : int'(r3[3:0]);
        int unsigned wv    = (r3[7:4] == 4'd0) ? 16 : int'(r3[7:4]);
        int unsigned hc    = t % hcn;
        int unsigned line  = t / hcn;
        int unsigned lf    = line % fl;
        int unsigned base  = (line >= fl) ? int'(sa) : 0;
        bit          rows  = lf < rowl;
        int unsigned row   = rows ? lf / sl : 0;
        int unsigned ra    = rows ? lf % sl : 0;
        int unsigned n_adv;
        int unsigned ma;
        bit          de, h, v;
        // Row base steps by R1 at every line end that closes scan line R9.
        n_adv = rows ? lf / sl : (int'(r4) + 1) + ((r9 == 0) ? lf - rowl : 0);
        ma    = (base + n_adv * int'(r1) + hc) % 16384;
        de    = (t > 0) && (hc < int'(r1)) && rows && (row < int'(r6));
        h     = 1'b0;
        for (int unsigned k = 0; k < wh; k++) begin
            if (t >= k + 1 && ((t - k) % hcn) == int'(r2)) h = 1'b1;
        end
        v = 1'b0;
        for (int unsigned k = 0; k < wv; k++) begin
            if (line >= k + 1) begin
                int unsigned lk = (line - k) % fl;
                if (lk < rowl && (lk % sl) == 0 && (lk / sl) == int'(r7)) v = 1'b1;
            end
        end
        return {h, v, de, 14'(ma), 5'(ra)};
    endfunction

    // mode 0: enable every clock, 1: every 4th clock, 2: random enable.
    task automatic run(input int unsigned n, input int unsigned mode, input int unsigned period);
        logic [21:0] m;
        for (int unsigned i = 0; i < n; i++) begin
            if (mode == 0)      cclk_en = 1'b1;
            else if (mode == 1) cclk_en = (cyc % 4 == 0);
            else                cclk_en = ($urandom_range(0, 2) == 0);
            @(posedge clk16);
            cyc++;
            if (!res_b) begin
                t_char  = 0;
                fs_exp  = 1'b0;
                last_fs = -1;
            end else if (cclk_en) begin
                t_char++;
                fs_exp = (t_char % frame_chars()) == 0;
            end else begin
                fs_exp = 1'b0;
            end
            #1;
            m = model(t_char);
            check("outputs",
                  {9'd0, bus.h_sync, bus.v_sync, bus.de, bus.frame_start, bus.ma, bus.ra},
                  {9'd0, m[21:19], fs_exp, m[18:0]});
            if (bus.frame_start === 1'b1) begin
                if (last_fs < 0) check("fs_first", t_char, frame_chars());
                else if (period != 0) check("fs_period", cyc - last_fs, period);
                last_fs = cyc;
            end
        end
    endtask

    task automatic base_cfg();
        r0 = 8'd9;  r1 = 8'd6; r2 = 8'd7; r3 = 8'h22;
        r4 = 7'd3;  r5 = 5'd2; r6 = 7'd2; r7 = 7'd3; r9 = 5'd1;
        sa = 14'h3FFE;
    endtask

    task automatic do_reset(input int unsigned n, input int unsigned mode);
        res_b = 1'b0;
        run(n, mode, 0);
        res_b = 1'b1;
    endtask

    initial begin
        base_cfg();
        do_reset(3, 0);
        run(350, 0, 100);
        // Mid-frame reset, then restart from MA base 0.
        do_reset(5, 0);
        run(250, 0, 100);

        base_cfg();
        r0 = 8'd31; r2 = 8'd30; r3 = 8'h00;
        do_reset(3, 0);
        run(700, 0, 320);

        base_cfg();
        r5 = 5'd0;
        do_reset(4, 1);
        run(1000, 1, 320);

        for (int s = 0; s < 6; s++) begin
            r0 = 8'($urandom_range(3, 15));
            r1 = 8'($urandom_range(0, int'(r0) + 2));
            r2 = 8'($urandom_range(0, int'(r0)));
            r3 = 8'($urandom_range(0, 255));
            r4 = 7'($urandom_range(0, 4));
            r5 = 5'($urandom_range(0, 3));
            r6 = 7'($urandom_range(0, int'(r4) + 1));
            r7 = 7'($urandom_range(0, int'(r4) + 1));
            r9 = 5'($urandom_range(0, 3));
            sa = 14'($urandom_range(0, 16383));
            do_reset(2, 2);
            run(700, 2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
